// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: first-word fall-through FIFO of {PC, instruction} pairs between IF and ID
module if_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_address,
    input  logic [INSTR_W-1:0]         in_instruction,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_address,
    output logic [ADDR_W-1:0]          out_pc_plus4,
    output logic [INSTR_W-1:0]         out_instruction,
    output logic                       out_misaligned,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0]  addr_mem  [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]   mis_mem;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic               push, pop;
    always_comb begin
        in_ready        = (count != CW'(DEPTH)) & Reset;
        out_valid       = count != '0;
        push            = in_valid & in_ready & ~flush;
        pop             = out_valid & out_ready & ~flush;
        out_address     = addr_mem[rd_ptr];
        out_pc_plus4    = out_address + ADDR_W'(4);
        out_instruction = out_valid ? instr_mem[rd_ptr] : '0;
        out_misaligned  = out_valid & mis_mem[rd_ptr];
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            mis_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr]  <= in_address;
                instr_mem[wr_ptr] <= in_instruction;
                mis_mem[wr_ptr]   <= in_address[1:0] != 2'b00;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: directed self-checking bench for if_fetch_buffer
module tb_if_fetch_buffer;
    logic        Clk = 0;
    logic        Reset = 1;
    logic        in_valid = 0;
    logic [31:0] in_address = 0;
    logic [31:0] in_instruction = 0;
    logic        in_ready;
    logic        flush = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_address, out_pc_plus4, out_instruction;
    logic        out_misaligned;
    logic [2:0]  count;
    int vectors = 0;
    int errors = 0;
    logic [31:0] tbl [4] = '{32'h20080001, 32'h20090002, 32'h200A0003, 32'h200B0004};

    if_fetch_buffer dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_address(in_address),
        .in_instruction(in_instruction), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
        .out_pc_plus4(out_pc_plus4), .out_instruction(out_instruction),
        .out_misaligned(out_misaligned), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        in_valid = 1; in_address = a; in_instruction = d;
        step();
        in_valid = 0;
    endtask

    task automatic test_reset();
        #1 Reset = 0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        vectors++; if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instruction); end
        vectors++; if (out_address !== 32'h0 || out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_addr got %h/%h want 0/4", out_address, out_pc_plus4); end
        @(negedge Clk);
        Reset = 1;
        step();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_fill();
        out_ready = 0;
        for (int i = 0; i < 4; i++) push(32'(4 * i), tbl[i]);
        vectors++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got count=%0d rdy=%0b want 4/0", count, in_ready); end
        vectors++; if (out_valid !== 1'b1 || out_address !== 32'h0 || out_instruction !== 32'h20080001) begin errors++; $display("FAIL fill_head got v=%0b %h/%h want 1 0/20080001", out_valid, out_address, out_instruction); end
        push(32'h10, 32'hDEADBEEF);
        vectors++; if (count !== 3'd4 || out_instruction !== 32'h20080001) begin errors++; $display("FAIL fill_overflow got count=%0d instr=%h want 4/20080001", count, out_instruction); end
    endtask

    task automatic test_drain();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_address !== 32'(4 * i) || out_pc_plus4 !== 32'(4 * i + 4) || out_instruction !== tbl[i]) begin
                errors++; $display("FAIL drain_%0d got v=%0b %h/%h/%h want 1 %h/%h/%h", i, out_valid, out_address, out_pc_plus4, out_instruction, 32'(4 * i), 32'(4 * i + 4), tbl[i]);
            end
            step();
        end
        out_ready = 0;
        vectors++; if (out_valid !== 1'b0 || out_instruction !== 32'h0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%0b instr=%h count=%0d want 0/0/0", out_valid, out_instruction, count); end
    endtask

    task automatic test_back_to_back();
        push(32'h100, 32'hA0);
        push(32'h104, 32'hA1);
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1; in_address = 32'h108 + 32'(4 * k); in_instruction = 32'hA2 + 32'(k);
            vectors++;
            if (count !== 3'd2 || out_address !== 32'h100 + 32'(4 * k) || out_instruction !== 32'hA0 + 32'(k)) begin
                errors++; $display("FAIL b2b_%0d got count=%0d %h/%h want 2 %h/%h", k, count, out_address, out_instruction, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
            end
            step();
        end
        in_valid = 0;
        for (int k = 6; k < 8; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_address !== 32'h100 + 32'(4 * k) || out_instruction !== 32'hA0 + 32'(k)) begin
                errors++; $display("FAIL b2b_tail_%0d got v=%0b %h/%h want 1 %h/%h", k, out_valid, out_address, out_instruction, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
            end
            step();
        end
        out_ready = 0;
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got count=%0d want 0", count); end
    endtask

    task automatic test_flush();
        push(32'h200, 32'hB0);
        push(32'h204, 32'hB1);
        push(32'h208, 32'hB2);
        vectors++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got count=%0d want 3", count); end
        flush = 1; in_valid = 1; in_address = 32'h40; in_instruction = 32'h40404040; out_ready = 1;
        step();
        flush = 0; in_valid = 0; out_ready = 0;
        vectors++; if (count !== 3'd0 || out_valid !== 1'b0 || out_instruction !== 32'h0) begin errors++; $display("FAIL flush_clear got count=%0d v=%0b instr=%h want 0/0/0", count, out_valid, out_instruction); end
        push(32'h300, 32'h33);
        vectors++; if (count !== 3'd1 || out_address !== 32'h300 || out_instruction !== 32'h33) begin errors++; $display("FAIL flush_after got count=%0d %h/%h want 1 300/33", count, out_address, out_instruction); end
        out_ready = 1;
        step();
        out_ready = 0;
        vectors++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got count=%0d v=%0b want 0/0", count, out_valid); end
    endtask

    task automatic test_boundary();
        push(32'hFFFFFFFC, 32'h11);
        push(32'h00000012, 32'h22);
        push(32'h00000020, 32'h33);
        vectors++; if (out_address !== 32'hFFFFFFFC || out_pc_plus4 !== 32'h0 || out_misaligned !== 1'b0) begin errors++; $display("FAIL wrap_plus4 got %h/%h mis=%0b want fffffffc/0 0", out_address, out_pc_plus4, out_misaligned); end
        out_ready = 1;
        step();
        out_ready = 0;
        vectors++; if (out_address !== 32'h12 || out_pc_plus4 !== 32'h16 || out_misaligned !== 1'b1 || out_instruction !== 32'h22) begin errors++; $display("FAIL misaligned got %h/%h mis=%0b instr=%h want 12/16 1 22", out_address, out_pc_plus4, out_misaligned, out_instruction); end
        out_ready = 1;
        step();
        out_ready = 0;
        vectors++; if (out_address !== 32'h20 || out_misaligned !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL aligned_next got %h mis=%0b count=%0d want 20 0 1", out_address, out_misaligned, count); end
        push(32'h24, 32'h44);
        vectors++; if (count !== 3'd2) begin errors++; $display("FAIL pre_reset got count=%0d want 2", count); end
        #2 Reset = 0;
        #1;
        vectors++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_address !== 32'h0) begin errors++; $display("FAIL mid_reset got count=%0d v=%0b rdy=%0b addr=%h want 0/0/0/0", count, out_valid, in_ready, out_address); end
        @(negedge Clk);
        Reset = 1;
        step();
        vectors++; if (in_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL post_reset got rdy=%0b count=%0d want 1/0", in_ready, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
